// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: core writeback vs. program/debug loader.
// Ports: clk, reset (async active-low); core_*/ldr_* requester sides
// (req/we/addr/wdata in; rdata/ack out; core_stall); mem_* to data memory.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int FIXED_PRIO  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ack,
  output logic              core_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ack,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CW-1:0] LAT_M1 = CW'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     w_count_nx;
  // requester ids: 0 = core, 1 = loader
  logic              r_last;
  logic              r_win;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_ldr_rdata;
  logic              w_any;
  logic              w_grant;
  logic              w_busy;
  logic              w_last_beat;

  assign w_any       = core_req | ldr_req;
  assign w_busy      = (r_state == S_BUSY);
  assign w_last_beat = w_busy && (r_count == '0);

  // On a tie the round-robin pointer picks whoever was not served last.
  always_comb begin
    w_grant = 1'b0;
    if (core_req && !ldr_req)
      w_grant = 1'b0;
    else if (!core_req && ldr_req)
      w_grant = 1'b1;
    else if (FIXED_PRIO != 0)
      w_grant = 1'b0;
    else
      w_grant = ~r_last;
  end

  always_comb begin
    w_state_nx = r_state;
    w_count_nx = r_count;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nx = S_BUSY;
          w_count_nx = LAT_M1;
        end
      end
      S_BUSY: begin
        if (r_count != '0)
          w_count_nx = r_count - CW'(1);
        else
          w_state_nx = S_RESP;
      end
      S_RESP:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_last       <= 1'b1;
      r_win        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_rdata <= '0;
      r_ldr_rdata  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_count <= w_count_nx;
      if (r_state == S_IDLE && w_any) begin
        r_win   <= w_grant;
        r_last  <= w_grant;
        r_we    <= w_grant ? ldr_we : core_we;
        r_addr  <= w_grant ? ldr_addr : core_addr;
        r_wdata <= w_grant ? ldr_wdata : core_wdata;
      end
      // stores leave the requester's rdata untouched
      if (w_last_beat && !r_we) begin
        if (r_win)
          r_ldr_rdata  <= mem_rdata;
        else
          r_core_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_addr         = '0;
    mem_wdata        = '0;
    if (w_busy) begin
      mem_read_enable  = ~r_we;
      mem_write_enable = r_we & w_last_beat;
      mem_addr         = r_addr;
      mem_wdata        = r_wdata;
    end
  end

  assign core_ack   = (r_state == S_RESP) & ~r_win;
  assign ldr_ack    = (r_state == S_RESP) & r_win;
  assign core_stall = core_req & ~core_ack;
  assign core_rdata = r_core_rdata;
  assign ldr_rdata  = r_ldr_rdata;

endmodule
